vedic_dot_issuer: RTL

- Initiator for the do/done multiplier handshake used by the vedic16x16 multiplier.
- Accepts a stream of N signed-agnostic (unsigned) 16-bit operand pairs, issues one pair per cycle to a pipelined multiplier via mul_do, and collects each product on mul_done.
- Accumulates the products into a dot product; sits between the matrix-multiplier row/column fetch logic and one multiplier instance.
- Works with any fixed multiplier latency >= 1; it counts issued and returned products and never depends on the latency value.

---
 rtl/vedic_dot_issuer.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/vedic_dot_issuer.sv
// rtl/vedic_dot_issuer.sv - dot-product issuer driving a pipelined do/done multiplier
//
// Purpose:
//   Takes len operand pairs from an upstream valid/ready stream and issues one pair
//   per cycle to a pipelined multiplier (mul_do_o). It sums every product returned
//   on mul_done_i into an unsigned accumulator. When all len products are back it
//   publishes the sum on dot_o with a one-cycle dot_valid_o pulse. Only issued and
//   returned products are counted, so any fixed multiplier latency >= 1 works.
//
// Ports:
//   clk_i         rising-edge clock
//   reset_i       synchronous reset, active low (0 = reset)
//   start_i       one-cycle job request, sampled only while idle
//   len_i         element count, sampled with start_i
//   in_a_i/in_b_i operand pair; in_valid_i/in_ready_o handshake
//   mul_a_o/b_o   registered operands to the multiplier
//   mul_do_o      registered issue strobe, one product per high cycle
//   mul_result_i  product from the multiplier, qualified by mul_done_i
//   dot_o         final sum, held until the next job finishes
//   dot_valid_o   one-cycle pulse when dot_o updates
//   busy_o        high whenever a job is in progress

module vedic_dot_issuer #(
  parameter int LEN_W = 8,
  parameter int ACC_W = 40
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic [15:0]      in_a_i,
  input  logic [15:0]      in_b_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  output logic [15:0]      mul_a_o,
  output logic [15:0]      mul_b_o,
  output logic             mul_do_o,
  input  logic [31:0]      mul_result_i,
  input  logic             mul_done_i,
  output logic [ACC_W-1:0] dot_o,
  output logic             dot_valid_o,
  output logic             busy_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_FINISH
  } state_t;

  state_t             state_q, state_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   issued_q, issued_d;
  logic [LEN_W-1:0]   received_q, received_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [15:0]        mul_a_q, mul_a_d;
  logic [15:0]        mul_b_q, mul_b_d;
  logic               mul_do_q, mul_do_d;
  logic [ACC_W-1:0]   dot_q, dot_d;
  logic               dot_valid_q, dot_valid_d;

  logic               issue_hs;
  logic               collect;

  // Ready purely from state and issue count so upstream sees no combinational path
  // from its own valid.
  assign in_ready_o = (state_q == S_ISSUE) && (issued_q < len_q);
  assign issue_hs   = in_valid_i && in_ready_o;

  // Products are taken in any active state but only until len have arrived; stale
  // products left over from an aborted job therefore fall on the floor in IDLE.
  assign collect    = (state_q != S_IDLE) && mul_done_i && (received_q < len_q);

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    issued_d    = issued_q;
    received_d  = received_q;
    acc_d       = acc_q;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    mul_do_d    = 1'b0;
    dot_d       = dot_q;
    dot_valid_d = 1'b0;

    if (collect) begin
      acc_d      = acc_q + ACC_W'(mul_result_i);
      received_d = received_q + 1'b1;
    end

    if (issue_hs) begin
      mul_a_d  = in_a_i;
      mul_b_d  = in_b_i;
      mul_do_d = 1'b1;
      issued_d = issued_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          len_d      = len_i;
          issued_d   = '0;
          received_d = '0;
          acc_d      = '0;
          state_d    = (len_i == '0) ? S_FINISH : S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (issued_d == len_q) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        // Using the next-state count lets the final product land in the same cycle
        // the exit is decided.
        if (received_d == len_q) state_d = S_FINISH;
      end
      S_FINISH: begin
        dot_d       = acc_d;
        dot_valid_d = 1'b1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      issued_q    <= '0;
      received_q  <= '0;
      acc_q       <= '0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      mul_do_q    <= 1'b0;
      dot_q       <= '0;
      dot_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      issued_q    <= issued_d;
      received_q  <= received_d;
      acc_q       <= acc_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      mul_do_q    <= mul_do_d;
      dot_q       <= dot_d;
      dot_valid_q <= dot_valid_d;
    end
  end

  assign mul_a_o     = mul_a_q;
  assign mul_b_o     = mul_b_q;
  assign mul_do_o    = mul_do_q;
  assign dot_o       = dot_q;
  assign dot_valid_o = dot_valid_q;
  assign busy_o      = (state_q != S_IDLE);

endmodule
